tone_mixer: RTL and testbench
=============================

# tone_mixer

Multi-channel, time-multiplexed tone synthesiser and stereo mixer. It replaces the fixed per-waveform generators and the combinational divide-based volume path. Each channel has its own DDS phase accumulator, waveform mode, duty, 4-bit volume and pan. On every codec sample request, all channels are computed sequentially, summed with saturation, and presented as one stereo sample to `audio_codec` (`data_left`/`data_right`).

## Interface
- `CHANNELS`, 4: number of tone channels (1..16)
- `WIDTH`, 24: signed output sample width
- `PHASE_W`, 32: phase accumulator width (must be ≥ WIDTH+1)
- `sys_clk`  in  1: system clock
- `reset`  in  1: asynchronous, active-high reset
- `sample_req`  in  1: one-cycle pulse at sample rate (synchronous to sys_clk)
- `phase_inc`  in  CHANNELS*PHASE_W: per-channel tuning word, f·2^PHASE_W/fs; channel n at `[n*PHASE_W +: PHASE_W]`
- `mode`  in  CHANNELS*2: 00 off, 01 saw, 10 triangle, 11 square
- `duty`  in  CHANNELS*8: square threshold; 0 treated as 1
- `volume`  in  CHANNELS*4: gain = volume/16
- `pan`  in  CHANNELS*2: bit0 = feed left, bit1 = feed right
- `data_left`  out  WIDTH: signed mixed left sample, held between updates
- `data_right`  out  WIDTH: signed mixed right sample
- `sample_valid`  out  1: one-cycle pulse when outputs update
- `busy`  out  1: high while a frame is being computed
- `overrun`  out  1: sticky; set when `sample_req` arrives while busy

## Operation
- FSM states:
  - IDLE: `sample_req` → GEN with ch=0, clear both accumulators.
  - GEN: for channel ch, register waveform sample s from the current phase (pre-increment). Then phase += phase_inc, mod 2^PHASE_W; if mode is off, phase := 0. → MAC.
  - MAC: v = (s·volume) >>> 4, with a (WIDTH+4)-bit signed product and arithmetic shift. Add v to the left accumulator if pan[0] is set, and to the right accumulator if pan[1] is set. If ch = CHANNELS−1 → OUT; else ch++ → GEN.
  - OUT: saturate each accumulator to [−2^(WIDTH−1), 2^(WIDTH−1)−1], register to outputs, pulse `sample_valid`. → IDLE.
- Accumulator width: WIDTH + clog2(CHANNELS) + 1, signed.
- Waveforms (P = phase):
  - saw: s = P[PHASE_W−1 -: WIDTH] with MSB inverted.
  - triangle: t = P[PHASE_W−2 -: WIDTH], bitwise inverted if P[PHASE_W−1]; s = t with MSB inverted.
  - square: s = 2^(WIDTH−1)−1 if P[PHASE_W−1 -: 8] < duty_eff, else −2^(WIDTH−1).
  - off: s = 0.
- Per-channel inputs are sampled in that channel's GEN/MAC cycles. They are not latched at `sample_req`.
- `sample_req` in any state other than IDLE: ignored (no queueing), `overrun` := 1.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values (asynchronous): state IDLE, all phases 0, accumulators 0, `data_left`/`data_right` 0, `sample_valid` 0, `busy` 0, `overrun` 0.
- `sample_req` sampled high at edge k (IDLE):
  - `busy` is high after edge k through edge k+2·CHANNELS+1.
  - Outputs update and `sample_valid` = 1 after edge k+2·CHANNELS+1, for exactly one cycle.
  - Latency is 2·CHANNELS+1 cycles (9 for the default).
- `sample_req` in the same cycle as OUT is an overrun. The next request is accepted only from IDLE, at the earliest one cycle after the `sample_valid` cycle.
- Reset asserted mid-frame: frame aborted, no `sample_valid`, outputs return to 0.
- Minimum `sample_req` spacing without overrun: 2·CHANNELS+2 cycles.

## Test plan
- Reset → `data_left` = `data_right` = 0, `busy` = `sample_valid` = `overrun` = 0; assert reset mid-frame → no `sample_valid`, outputs 0, phases 0.
- Defaults; ch0: saw, phase_inc = 2^28, volume 15, pan 11; others off:
  - first frame → both outputs −7864320;
  - second → −6881280;
  - period of 16 frames.
- Single `sample_req` → `busy` high exactly 9 cycles, `sample_valid` once at cycle 9, outputs change only then.
- All 4 channels square, duty 255, volume 15, pan 11, phases 0 → sum 31457276 saturates → both outputs 8388607. Same with duty 0 → −2^23·15/16·4 saturates → −8388608.
- Second `sample_req` 3 cycles after the first → ignored, `overrun` = 1 and stays 1, only one `sample_valid`.
- ch0 saw, volume 15, pan 01; ch1 pan 11, mode off → `data_right` = 0, `data_left` follows ch0 saw values; ch1 phase stays 0.

Source files
------------

// File: rtl/tone_mixer.sv
// tone_mixer: time-multiplexed multi-channel DDS tone synthesiser with a
// saturating stereo mixer.
//
// On each sample_req pulse (accepted only while idle) every channel is visited
// in turn. A channel takes two cycles. The GEN cycle registers the waveform
// sample from the current phase and then advances the phase. The MAC cycle
// scales the sample by volume/16 and adds it to the left and/or right
// accumulator. A final OUT cycle saturates both accumulators to WIDTH bits and
// pulses sample_valid.
//
// Ports:
//   sys_clk, reset   clock, asynchronous active-high reset
//   sample_req       one-cycle frame request
//   phase_inc        per-channel tuning words, PHASE_W bits each
//   mode             per-channel waveform: 00 off, 01 saw, 10 triangle, 11 square
//   duty             per-channel square threshold (0 behaves as 1)
//   volume           per-channel 4-bit gain, volume/16
//   pan              per-channel routing: bit0 left, bit1 right
//   data_left/right  signed mixed samples, held between frames
//   sample_valid     one-cycle pulse when the outputs update
//   busy             high while a frame is in progress
//   overrun          sticky flag: a request arrived while busy
module tone_mixer #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 24,
   parameter int PHASE_W  = 32
) (
   input  logic                         sys_clk,
   input  logic                         reset,
   input  logic                         sample_req,
   input  logic [CHANNELS*PHASE_W-1:0]  phase_inc,
   input  logic [CHANNELS*2-1:0]        mode,
   input  logic [CHANNELS*8-1:0]        duty,
   input  logic [CHANNELS*4-1:0]        volume,
   input  logic [CHANNELS*2-1:0]        pan,
   output logic signed [WIDTH-1:0]      data_left,
   output logic signed [WIDTH-1:0]      data_right,
   output logic                         sample_valid,
   output logic                         busy,
   output logic                         overrun
);

   localparam int ACC_W = WIDTH + $clog2(CHANNELS) + 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] SQ_HI   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SQ_LO   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, GEN, MAC, OUT} state_t;

   state_t state, state_next;
   logic [CH_W-1:0] ch, ch_next;

   logic [PHASE_W-1:0] inc_arr   [CHANNELS];
   logic [PHASE_W-1:0] phase_arr [CHANNELS];
   logic [1:0]         mode_arr  [CHANNELS];
   logic [7:0]         duty_arr  [CHANNELS];
   logic [3:0]         vol_arr   [CHANNELS];
   logic [1:0]         pan_arr   [CHANNELS];

   logic signed [WIDTH-1:0] s_reg;
   logic signed [ACC_W-1:0] acc_l, acc_r;

   // Per-channel unpacking and phase accumulators. A phase only moves during
   // its own channel's GEN cycle; an off channel is parked at phase 0.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [PHASE_W-1:0] phase_q;

         assign inc_arr[gi]   = phase_inc[gi*PHASE_W +: PHASE_W];
         assign mode_arr[gi]  = mode[gi*2 +: 2];
         assign duty_arr[gi]  = duty[gi*8 +: 8];
         assign vol_arr[gi]   = volume[gi*4 +: 4];
         assign pan_arr[gi]   = pan[gi*2 +: 2];
         assign phase_arr[gi] = phase_q;

         always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
               phase_q <= '0;
            end else if (state == GEN && ch == CH_W'(gi)) begin
               if (mode_arr[gi] == 2'b00)
                  phase_q <= '0;
               else
                  phase_q <= phase_q + inc_arr[gi];
            end
         end
      end
   endgenerate

   // Waveform generation from the pre-increment phase of the current channel.
   logic [PHASE_W-1:0]      cur_phase;
   logic [7:0]              duty_eff;
   logic [WIDTH-1:0]        tri_t;
   logic signed [WIDTH-1:0] wave;

   always_comb begin
      cur_phase = phase_arr[ch];
      duty_eff  = (duty_arr[ch] == 8'd0) ? 8'd1 : duty_arr[ch];
      tri_t     = cur_phase[PHASE_W-2 -: WIDTH] ^ {WIDTH{cur_phase[PHASE_W-1]}};
      wave      = '0;
      case (mode_arr[ch])
         2'b01:   wave = {~cur_phase[PHASE_W-1], cur_phase[PHASE_W-2 -: WIDTH-1]};
         2'b10:   wave = {~tri_t[WIDTH-1], tri_t[WIDTH-2:0]};
         2'b11:   wave = (cur_phase[PHASE_W-1 -: 8] < duty_eff) ? SQ_HI : SQ_LO;
         default: wave = '0;
      endcase
   end

   // Volume scaling: the product of a WIDTH-bit sample and a 4-bit gain always
   // fits WIDTH+4 signed bits, and after the arithmetic shift the value fits in
   // WIDTH bits again, so the cast to ACC_W only sign-extends or drops copies of
   // the sign bit.
   logic signed [WIDTH+3:0] prod;
   logic signed [WIDTH+3:0] v_full;
   logic signed [ACC_W-1:0] v_ext;

   always_comb begin
      prod   = $signed({{4{s_reg[WIDTH-1]}}, s_reg}) * $signed({{WIDTH{1'b0}}, vol_arr[ch]});
      v_full = prod >>> 4;
      v_ext  = ACC_W'(v_full);
   end

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)
         return WIDTH'(SAT_MAX);
      else if (a < SAT_MIN)
         return WIDTH'(SAT_MIN);
      else
         return WIDTH'(a);
   endfunction

   // Frame sequencing: GEN/MAC for each channel, then a single OUT cycle.
   always_comb begin
      state_next = state;
      ch_next    = ch;
      case (state)
         IDLE: begin
            if (sample_req) begin
               state_next = GEN;
               ch_next    = '0;
            end
         end
         GEN: state_next = MAC;
         MAC: begin
            if (ch == LAST_CH) begin
               state_next = OUT;
            end else begin
               ch_next    = ch + 1'b1;
               state_next = GEN;
            end
         end
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         ch           <= '0;
         s_reg        <= '0;
         acc_l        <= '0;
         acc_r        <= '0;
         data_left    <= '0;
         data_right   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_next;
         ch           <= ch_next;
         sample_valid <= (state == OUT);
         if (sample_req && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (sample_req) begin
                  acc_l <= '0;
                  acc_r <= '0;
               end
            end
            GEN: s_reg <= wave;
            MAC: begin
               if (pan_arr[ch][0]) acc_l <= acc_l + v_ext;
               if (pan_arr[ch][1]) acc_r <= acc_r + v_ext;
            end
            OUT: begin
               data_left  <= sat(acc_l);
               data_right <= sat(acc_r);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_tone_mixer.sv
// Self-checking bench for tone_mixer. A behavioural model computes every
// frame from the waveform, gain and mixing rules using plain integer arithmetic,
// and each frame is also checked for busy/sample_valid timing and output hold.
module tb_tone_mixer;

   localparam int C  = 4;
   localparam int W  = 24;
   localparam int PW = 32;
   localparam longint HALF  = 64'sd1 <<< (W-1);
   localparam longint FULLW = 64'sd1 <<< W;
   localparam longint PMASK = (64'sd1 <<< PW) - 1;

   logic                  sys_clk = 1'b0;
   logic                  reset;
   logic                  sample_req;
   logic [C*PW-1:0]       phase_inc;
   logic [C*2-1:0]        mode;
   logic [C*8-1:0]        duty;
   logic [C*4-1:0]        volume;
   logic [C*2-1:0]        pan;
   logic signed [W-1:0]   data_left;
   logic signed [W-1:0]   data_right;
   logic                  sample_valid;
   logic                  busy;
   logic                  overrun;

   tone_mixer #(.CHANNELS(C), .WIDTH(W), .PHASE_W(PW)) dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .sample_req   (sample_req),
      .phase_inc    (phase_inc),
      .mode         (mode),
      .duty         (duty),
      .volume       (volume),
      .pan          (pan),
      .data_left    (data_left),
      .data_right   (data_right),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   int     n_assert = 0;
   int     n_fail   = 0;
   longint mphase [C];
   logic   exp_ovr;
   longint first_l;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [PW-1:0] inc, input logic [1:0] md,
                         input logic [7:0] dt, input logic [3:0] vol, input logic [1:0] pn);
      phase_inc[c*PW +: PW] = inc;
      mode[c*2 +: 2]        = md;
      duty[c*8 +: 8]        = dt;
      volume[c*4 +: 4]      = vol;
      pan[c*2 +: 2]         = pn;
   endtask

   task automatic model_reset();
      for (int c = 0; c < C; c++) mphase[c] = 0;
      exp_ovr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   // Reference: one full frame computed from the current configuration.
   task automatic model_frame(output longint l, output longint r);
      longint p, s, v, inc, t, d, top;
      int     md, vol, pn;
      l = 0;
      r = 0;
      for (int c = 0; c < C; c++) begin
         p   = mphase[c];
         md  = int'(mode[c*2 +: 2]);
         vol = int'(volume[c*4 +: 4]);
         pn  = int'(pan[c*2 +: 2]);
         inc = longint'(phase_inc[c*PW +: PW]);
         d   = longint'(duty[c*8 +: 8]);
         if (d == 0) d = 1;
         case (md)
            1: s = (p >> (PW-W)) - HALF;
            2: begin
               t = (p >> (PW-1-W)) % FULLW;
               if (p >= (64'sd1 <<< (PW-1))) t = FULLW - 1 - t;
               s = t - HALF;
            end
            3: begin
               top = p >> (PW-8);
               s = (top < d) ? HALF - 1 : -HALF;
            end
            default: s = 0;
         endcase
         v = (s * vol) >>> 4;
         if (pn % 2 == 1) l += v;
         if (pn >= 2) r += v;
         mphase[c] = (md == 0) ? 0 : ((p + inc) & PMASK);
      end
      if (l > HALF - 1) l = HALF - 1;
      if (l < -HALF) l = -HALF;
      if (r > HALF - 1) r = HALF - 1;
      if (r < -HALF) r = -HALF;
   endtask

   // Issue one request, watch the frame, check timing and the mixed result.
   // extra_at >= 0 raises a second request that many cycles into the frame.
   task automatic run_frame(input string tag, input int extra_at);
      longint el, er;
      int busy_n, valid_n, valid_c, early;
      logic signed [W-1:0] prev_l, prev_r;
      busy_n  = 0;
      valid_n = 0;
      valid_c = -1;
      early   = 0;
      prev_l  = data_left;
      prev_r  = data_right;
      model_frame(el, er);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      for (int c = 0; c < 2*C+5; c++) begin
         if (busy === 1'b1) busy_n++;
         if (sample_valid === 1'b1) begin
            valid_n++;
            valid_c = c;
         end
         if (data_left !== prev_l || data_right !== prev_r) begin
            if (sample_valid !== 1'b1) early++;
            prev_l = data_left;
            prev_r = data_right;
         end
         sample_req = (c == extra_at);
         tick();
      end
      sample_req = 1'b0;
      if (extra_at >= 0) exp_ovr = 1'b1;
      chk({tag, " busy_cycles"}, busy_n, 2*C+1);
      chk({tag, " valid_count"}, valid_n, 1);
      chk({tag, " valid_cycle"}, valid_c, 2*C+1);
      chk({tag, " early_update"}, early, 0);
      chk({tag, " left"}, $signed(data_left), el);
      chk({tag, " right"}, $signed(data_right), er);
      chk({tag, " overrun"}, overrun, exp_ovr);
      $display("frame %s: left=%0d right=%0d (model %0d/%0d) overrun=%0b",
               tag, data_left, data_right, el, er, overrun);
   endtask

   initial begin
      int vcount;
      reset      = 1'b1;
      sample_req = 1'b0;
      phase_inc  = '0;
      mode       = '0;
      duty       = '0;
      volume     = '0;
      pan        = '0;
      model_reset();
      tick();
      tick();
      chk("reset left", $signed(data_left), 0);
      chk("reset right", $signed(data_right), 0);
      chk("reset busy", busy, 0);
      chk("reset valid", sample_valid, 0);
      chk("reset overrun", overrun, 0);
      reset = 1'b0;
      tick();

      // Saw on channel 0, 16-frame period; other channels off with junk gains.
      set_ch(0, 32'h1000_0000, 2'b01, 8'd0, 4'd15, 2'b11);
      for (int c = 1; c < C; c++) set_ch(c, 32'h0123_4567 * (c+1), 2'b00, 8'd77, 4'd9, 2'b11);
      run_frame("saw1", -1);
      chk("saw1 const", $signed(data_left), -7864320);
      first_l = longint'($signed(data_left));
      run_frame("saw2", -1);
      chk("saw2 const", $signed(data_right), -6881280);
      for (int f = 3; f <= 17; f++) run_frame($sformatf("saw%0d", f), -1);
      chk("saw period", $signed(data_left), first_l);

      // Second request three cycles after the first, then confirm stickiness.
      run_frame("ovr3", 2);
      run_frame("ovr_sticky", -1);

      // Reset in the middle of a frame.
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midrst left", $signed(data_left), 0);
      chk("midrst right", $signed(data_right), 0);
      chk("midrst busy", busy, 0);
      chk("midrst overrun", overrun, 0);
      tick();
      reset = 1'b0;
      model_reset();
      vcount = 0;
      for (int c = 0; c < 2*C+4; c++) begin
         if (sample_valid === 1'b1) vcount++;
         tick();
      end
      chk("midrst no_valid", vcount, 0);
      run_frame("post_rst", -1);
      chk("post_rst phase0", $signed(data_left), -7864320);

      // Left-only channel 0, channel 1 off but routed to both sides.
      set_ch(0, 32'h1000_0000, 2'b01, 8'd0, 4'd15, 2'b01);
      set_ch(1, 32'h2000_0000, 2'b00, 8'd0, 4'd15, 2'b11);
      for (int f = 0; f < 3; f++) begin
         run_frame($sformatf("pan%0d", f), -1);
         chk("pan right zero", $signed(data_right), 0);
      end
      set_ch(0, 32'h1000_0000, 2'b00, 8'd0, 4'd15, 2'b01);
      set_ch(1, 32'h1000_0000, 2'b01, 8'd0, 4'd15, 2'b11);
      run_frame("ch1_phase0", -1);
      chk("ch1 phase0", $signed(data_right), -7864320);

      // Square saturation in both directions.
      do_reset();
      for (int c = 0; c < C; c++) set_ch(c, 32'h1000_0000, 2'b11, 8'd255, 4'd15, 2'b11);
      run_frame("sq_hi", -1);
      chk("sq_hi sat", $signed(data_left), 8388607);
      for (int c = 0; c < C; c++) set_ch(c, 32'h1000_0000, 2'b11, 8'd0, 4'd15, 2'b11);
      run_frame("sq_lo", -1);
      chk("sq_lo sat", $signed(data_right), -8388608);

      // Request landing in the OUT cycle is an overrun.
      do_reset();
      run_frame("ovr_out", 2*C);

      // Randomised configurations, including triangle waves.
      do_reset();
      for (int f = 0; f < 40; f++) begin
         for (int c = 0; c < C; c++)
            set_ch(c, $urandom, 2'($urandom_range(0, 3)), 8'($urandom),
                   4'($urandom), 2'($urandom));
         run_frame($sformatf("rnd%0d", f), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
